uart_hex_tx: RTL and testbench



---
 rtl/uart_hex_tx.sv | 181 ++++++++++++++++++
 tb/tb_uart_hex_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - 32-bit word to ASCII hex byte feeder for a busy-less UART transmitter
module uart_hex_tx #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 10000,
    parameter int NEWLINE    = 1
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        hex_valid_i,
    input  logic [31:0] hex_dat_i,
    output logic        hex_ready_o,
    output logic        uart_wr_o,
    output logic [7:0]  uart_dat_o,
    output logic        idle_o
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [3:0]  LAST_IDX = (NEWLINE != 0) ? 4'd9 : 4'd7;
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    // Character index 8/9 are the line terminator; 0..7 are hex digits of the nibble
    function automatic logic [7:0] enc_char(input logic [3:0] idx, input logic [3:0] nib);
        logic [7:0] c;
        if (idx == 4'd8) begin
            c = 8'h0D;
        end else if (idx == 4'd9) begin
            c = 8'h0A;
        end else if (nib <= 4'd9) begin
            c = 8'h30 + {4'h0, nib};
        end else begin
            c = 8'h37 + {4'h0, nib};
        end
        return c;
    endfunction

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;
    logic [31:0]   head;

    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    nxt_idx;
    logic [15:0]   gap_q, gap_d;
    logic          wr_q, wr_d;
    logic [7:0]    dat_q, dat_d;
    logic          ready_q, ready_d;
    logic          idle_q, idle_d;

    // A word is only accepted while the registered ready says there is room
    assign push = hex_valid_i & ready_q;
    assign head = mem_q[rd_ptr_q];

    // FIFO occupancy and registered status flags follow from the push/pop decision
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
        idle_d  = (state_d == S_IDLE) && (count_d == '0);
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= hex_dat_i;
        end
    end

    // FIFO pointers, count and handshake flags
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            idle_q   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ready_q <= ready_d;
            idle_q  <= idle_d;
        end
    end

    // Next state: the strobe and its byte are computed one cycle ahead so both come
    // straight from flops; word_q holds the nibbles not yet sent, MSB first.
    // At the end of the last gap a queued word is popped directly so the spacing
    // across word boundaries stays exactly one gap.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        wr_d    = 1'b0;
        dat_d   = dat_q;
        pop     = 1'b0;
        nxt_idx = idx_q + 4'd1;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    word_d  = {head[27:0], 4'h0};
                    idx_d   = 4'd0;
                    wr_d    = 1'b1;
                    dat_d   = enc_char(4'd0, head[31:28]);
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                gap_d   = GAP_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                gap_d = gap_q - 16'd1;
                if (gap_q == 16'd1) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = nxt_idx;
                        word_d  = {word_q[27:0], 4'h0};
                        wr_d    = 1'b1;
                        dat_d   = enc_char(nxt_idx, word_q[31:28]);
                        state_d = S_SEND;
                    end else if (count_q != '0) begin
                        pop     = 1'b1;
                        word_d  = {head[27:0], 4'h0};
                        idx_d   = 4'd0;
                        wr_d    = 1'b1;
                        dat_d   = enc_char(4'd0, head[31:28]);
                        state_d = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, shift register, gap counter and output registers
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
        end
    end

    assign hex_ready_o = ready_q;
    assign uart_wr_o   = wr_q;
    assign uart_dat_o  = dat_q;
    assign idle_o      = idle_q;

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb/tb_uart_hex_tx.sv - self-checking bench for uart_hex_tx
module tb_uart_hex_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected byte i of a printed word, straight from the ASCII hex rule
    function automatic logic [7:0] exp_char(input logic [31:0] w, input int i);
        int n;
        if (i == 8) return 8'h0D;
        if (i == 9) return 8'h0A;
        n = (w >> (28 - 4 * i)) & 15;
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    // Instance a: GAP 16, newline on
    logic rst_a, valid_a, ready_a, wr_a, idle_a;
    logic [31:0] dat_a;
    logic [7:0]  udat_a;
    uart_hex_tx #(.DEPTH(4), .GAP_CYCLES(16), .NEWLINE(1)) dut_a (
        .sys_clk_i(clk), .sys_rst_i(rst_a), .hex_valid_i(valid_a), .hex_dat_i(dat_a),
        .hex_ready_o(ready_a), .uart_wr_o(wr_a), .uart_dat_o(udat_a), .idle_o(idle_a));

    // Instance b: GAP 16, newline off
    logic rst_b, valid_b, ready_b, wr_b, idle_b;
    logic [31:0] dat_b;
    logic [7:0]  udat_b;
    uart_hex_tx #(.DEPTH(4), .GAP_CYCLES(16), .NEWLINE(0)) dut_b (
        .sys_clk_i(clk), .sys_rst_i(rst_b), .hex_valid_i(valid_b), .hex_dat_i(dat_b),
        .hex_ready_o(ready_b), .uart_wr_o(wr_b), .uart_dat_o(udat_b), .idle_o(idle_b));

    // Instance c: short gap, newline on, random traffic
    logic rst_c, valid_c, ready_c, wr_c, idle_c;
    logic [31:0] dat_c;
    logic [7:0]  udat_c;
    uart_hex_tx #(.DEPTH(4), .GAP_CYCLES(3), .NEWLINE(1)) dut_c (
        .sys_clk_i(clk), .sys_rst_i(rst_c), .hex_valid_i(valid_c), .hex_dat_i(dat_c),
        .hex_ready_o(ready_c), .uart_wr_o(wr_c), .uart_dat_o(udat_c), .idle_o(idle_c));

    logic [7:0] qa[$];
    int         ta[$];
    logic [7:0] qb[$];
    int         tb[$];
    logic [7:0] expc[$];
    logic pwa = 1'b0, pwb = 1'b0, pwc = 1'b0;
    int   lastc = -1;
    int   cnt_c = 0;

    always @(negedge clk) begin
        if (wr_a === 1'b1) begin
            check("a_consec", pwa, 0);
            qa.push_back(udat_a);
            ta.push_back(cyc);
        end
        pwa = (wr_a === 1'b1);
    end

    always @(negedge clk) begin
        if (wr_b === 1'b1) begin
            check("b_consec", pwb, 0);
            qb.push_back(udat_b);
            tb.push_back(cyc);
        end
        pwb = (wr_b === 1'b1);
    end

    always @(negedge clk) begin
        if (wr_c === 1'b1) begin
            check("c_consec", pwc, 0);
            if (expc.size() == 0) check("c_extra", 1, 0);
            else check("c_byte", udat_c, expc.pop_front());
            if (lastc >= 0) check("c_gap", (cyc - lastc) >= 3, 1);
            lastc = cyc;
            cnt_c++;
        end
        pwc = (wr_c === 1'b1);
    end

    initial begin
        logic [31:0] w;
        logic        r;
        int          acc, first_acc, sent, rise, done_at;
        logic [31:0] wa[6];

        rst_a = 1; rst_b = 1; rst_c = 1;
        valid_a = 0; valid_b = 0; valid_c = 0;
        dat_a = '0; dat_b = '0; dat_c = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 0; rst_b = 0; rst_c = 0;

        check("rst_wr", wr_a, 0);
        check("rst_dat", udat_a, 8'h00);
        check("rst_ready", ready_a, 1);
        check("rst_idle", idle_a, 1);

        // Single word with newline
        valid_a = 1; dat_a = 32'h1234ABCD;
        @(posedge clk); #1;
        acc = cyc;
        valid_a = 0;
        for (int i = 0; i < 400 && qa.size() < 10; i++) @(posedge clk);
        #1;
        check("t1_count", qa.size(), 10);
        if (qa.size() == 10) begin
            check("t1_first_lat", ta[0], acc + 1);
            for (int i = 0; i < 10; i++) check("t1_byte", qa[i], exp_char(32'h1234ABCD, i));
            for (int i = 1; i < 10; i++) check("t1_gap", ta[i] - ta[i-1], 16);
            done_at = ta[9];
            while (cyc < done_at + 10) begin @(posedge clk); #1; end
            check("t1_busy", idle_a, 0);
            while (cyc < done_at + 20) begin @(posedge clk); #1; end
            check("t1_idle", idle_a, 1);
        end

        // Two back-to-back words without newline
        valid_b = 1; dat_b = 32'h0000000F;
        check("t2_ready0", ready_b, 1);
        @(posedge clk); #1;
        dat_b = 32'hFFFFFFFF;
        check("t2_ready1", ready_b, 1);
        @(posedge clk); #1;
        valid_b = 0;
        for (int i = 0; i < 600 && qb.size() < 16; i++) @(posedge clk);
        #1;
        check("t2_count", qb.size(), 16);
        if (qb.size() == 16) begin
            for (int i = 0; i < 8; i++) check("t2_byte0", qb[i], exp_char(32'h0000000F, i));
            for (int i = 0; i < 8; i++) check("t2_byte1", qb[8+i], exp_char(32'hFFFFFFFF, i));
            for (int i = 1; i < 16; i++) check("t2_gap", tb[i] - tb[i-1], 16);
        end

        // Backpressure: hold valid with words 1..6
        qa.delete(); ta.delete();
        sent = 0; rise = -1; first_acc = -1;
        valid_a = 1; dat_a = 32'd1;
        for (int i = 0; i < 600 && sent < 6; i++) begin
            r = ready_a;
            @(posedge clk); #1;
            if (r) begin
                sent++;
                if (sent == 1) first_acc = cyc;
                if (sent == 5) begin
                    check("t3_burst", cyc - first_acc, 4);
                    check("t3_ready_drop", ready_a, 0);
                end
                dat_a = sent + 1;
            end else if (ready_a && rise < 0) begin
                rise = cyc;
            end
        end
        valid_a = 0;
        check("t3_sent", sent, 6);
        for (int i = 0; i < 1500 && qa.size() < 60; i++) @(posedge clk);
        #1;
        check("t3_count", qa.size(), 60);
        if (qa.size() == 60) begin
            for (int k = 0; k < 6; k++)
                for (int i = 0; i < 10; i++) check("t3_byte", qa[10*k+i], exp_char(k + 1, i));
            check("t3_ready_rise", rise, ta[10]);
            check("t3_word_gap", ta[10] - ta[9], 16);
        end
        repeat (30) @(posedge clk);
        #1;

        // Reset during the fourth byte's gap with two words queued
        qa.delete(); ta.delete();
        wa[0] = 32'hA5A5A5A5; wa[1] = 32'h11111111; wa[2] = 32'h22222222;
        valid_a = 1;
        for (int k = 0; k < 3; k++) begin
            dat_a = wa[k];
            @(posedge clk); #1;
        end
        valid_a = 0;
        for (int i = 0; i < 200 && qa.size() < 4; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("t4_pre_count", qa.size(), 4);
        rst_a = 1;
        @(posedge clk); #1;
        rst_a = 0;
        check("t4_wr", wr_a, 0);
        check("t4_dat", udat_a, 8'h00);
        check("t4_ready", ready_a, 1);
        check("t4_idle", idle_a, 1);
        repeat (100) @(posedge clk);
        #1;
        check("t4_silent", qa.size(), 4);
        if (qa.size() >= 4) check("t4_last", qa[3], exp_char(32'hA5A5A5A5, 3));
        valid_a = 1; dat_a = 32'h9ABCDEF0;
        @(posedge clk); #1;
        valid_a = 0;
        for (int i = 0; i < 20 && qa.size() < 5; i++) @(posedge clk);
        #1;
        check("t4_resume", qa.size(), 5);
        if (qa.size() >= 5) check("t4_resume_byte", qa[4], exp_char(32'h9ABCDEF0, 0));

        // Random traffic against a scoreboard
        for (int n = 0; n < 1000; n++) begin
            w = $urandom;
            valid_c = 0;
            dat_c = $urandom;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            valid_c = 1; dat_c = w;
            r = 0;
            for (int i = 0; i < 200 && !r; i++) begin
                r = ready_c;
                @(posedge clk); #1;
            end
            if (!r) check("t6_accept_timeout", 0, 1);
            else for (int i = 0; i < 10; i++) expc.push_back(exp_char(w, i));
            valid_c = 0;
        end
        for (int i = 0; i < 2000 && expc.size() != 0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("t6_drained", expc.size(), 0);
        check("t6_count", cnt_c, 10000);
        check("t6_idle", idle_c, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
